// File: rtl/adc_proc_pkg.sv
// Shared types and width helpers for the multi-channel ADC post-processor.
package adc_proc_pkg;

   localparam int CH_W  = 3;   // channel index, up to 8 channels
   localparam int PAY_W = 64;  // stage payload, wide enough for any window sum or product

   function automatic int log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int sum_w(input int data_w, input int depth);
      return data_w + log2(depth);
   endfunction

   function automatic int prod_w(input int data_w, input int scale_w);
      return data_w + scale_w;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int ptr_w(input int n);
      return (n > 1) ? log2(n) : 1;
   endfunction

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [PAY_W-1:0] val;
      logic             valid;
   } stage_t;

endpackage

// File: rtl/multi_adc_processing_if.sv
// Sample inputs and per-channel result outputs of the ADC post-processor.
interface multi_adc_processing_if #(
   parameter int N_CH   = 3,
   parameter int DATA_W = 16
);
   // sample_valid[i] is a one-cycle strobe with no backpressure: the block always
   // accepts it, and a sample still waiting for service when the next one arrives
   // is replaced and flagged in overrun[i]. update_valid[i] strobes once per result.
   logic [N_CH-1:0]        sample_valid;
   logic [N_CH*DATA_W-1:0] sample_data;
   logic                   clear_overrun;
   logic [N_CH*DATA_W-1:0] ave_data;
   logic [N_CH*DATA_W-1:0] scaled_data;
   logic [N_CH-1:0]        update_valid;
   logic [N_CH-1:0]        primed;
   logic [N_CH-1:0]        overrun;

   modport master (
      output sample_valid, sample_data, clear_overrun,
      input  ave_data, scaled_data, update_valid, primed, overrun
   );

   modport slave (
      input  sample_valid, sample_data, clear_overrun,
      output ave_data, scaled_data, update_valid, primed, overrun
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last grant.
module rr_arbiter
   import adc_proc_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [ptr_w(N)-1:0]  grant_idx
);
   localparam int IW = ptr_w(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      ptr_d     = ptr_q;
      for (int c = 0; c < N; c++) begin
         if (!found && req[c] && IW'(c) >= ptr_q) begin
            found     = 1'b1;
            grant[c]  = 1'b1;
            grant_idx = IW'(c);
         end
      end
      for (int c = 0; c < N; c++) begin
         if (!found && req[c] && IW'(c) < ptr_q) begin
            found     = 1'b1;
            grant[c]  = 1'b1;
            grant_idx = IW'(c);
         end
      end
      if (advance && found) ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
endmodule

// File: rtl/multi_adc_processing.sv
// N-channel ADC post-processor: per-channel capture and moving average feeding
// one shared, round-robin scheduled scale/offset/clamp pipeline.
module multi_adc_processing
   import adc_proc_pkg::*;
#(
   parameter int          N_CH           = 3,
   parameter int          DATA_W         = 16,
   parameter int          DEPTH          = 16,
   parameter int unsigned SCALING_FACTOR = 310866,
   parameter int          SCALE_W        = 20,
   parameter int          SHIFT_FACTOR   = 19,
   parameter int unsigned OFFSET         = 0
) (
   input logic                   clk,
   input logic                   reset,
   multi_adc_processing_if.slave bus
);
   localparam int SUM_W  = sum_w(DATA_W, DEPTH);
   localparam int PROD_W = prod_w(DATA_W, SCALE_W);
   localparam int PTR_W  = ptr_w(DEPTH);
   localparam int LOG_D  = log2(DEPTH);
   localparam int FILL_W = LOG_D + 1;
   localparam int RING_N = 1 << PTR_W;
   localparam int IDX_W  = ptr_w(N_CH);
   localparam logic [SCALE_W-1:0] SCALE   = SCALE_W'(SCALING_FACTOR);
   localparam logic [PROD_W-1:0]  OFS     = PROD_W'(OFFSET);
   localparam logic [PROD_W-1:0]  SAT_MAX = PROD_W'({DATA_W{1'b1}});

   logic [DATA_W-1:0] hold_q   [N_CH];
   logic [SUM_W-1:0]  sum_q    [N_CH];
   logic [DATA_W-1:0] ring_q   [N_CH][RING_N];
   logic [PTR_W-1:0]  wp_q     [N_CH];
   logic [FILL_W-1:0] fill_q   [N_CH];
   logic [DATA_W-1:0] ave_q    [N_CH];
   logic [DATA_W-1:0] scaled_q [N_CH];
   logic [N_CH-1:0]   pending_q, pending_d, overrun_q, overrun_d, primed_q, upd_q, upd_d;
   stage_t            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [DATA_W-1:0] ave3_q, ave3_d, scaled4_d, d1;
   logic [N_CH-1:0]   grant;
   logic [IDX_W-1:0]  grant_idx, c1, c3;
   logic [SUM_W-1:0]  sum_new;
   logic [PTR_W-1:0]  wp_next;
   logic [FILL_W-1:0] fill_next;
   logic [PROD_W-1:0] prod3, sh, sh_ofs;
   logic              unused_payload;

   rr_arbiter #(.N(N_CH)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (pending_q),
      .advance   (1'b1),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // A granted channel hands over its old hold value, so a same-cycle strobe is not an overrun.
   always_comb begin
      pending_d = (pending_q & ~grant) | bus.sample_valid;
      overrun_d = (bus.clear_overrun ? '0 : overrun_q) | (bus.sample_valid & pending_q & ~grant);
   end

   always_comb begin
      s1_d       = '0;
      s1_d.valid = |pending_q;
      s1_d.ch    = CH_W'(grant_idx);
      s1_d.val   = PAY_W'(hold_q[grant_idx]);

      // Sum, pointer and fill are read and written in the same stage: no forwarding needed.
      c1        = IDX_W'(s1_q.ch);
      d1        = DATA_W'(s1_q.val);
      sum_new   = sum_q[c1] - SUM_W'(ring_q[c1][wp_q[c1]]) + SUM_W'(d1);
      wp_next   = (wp_q[c1] == PTR_W'(DEPTH - 1)) ? '0 : wp_q[c1] + PTR_W'(1);
      fill_next = (fill_q[c1] == FILL_W'(DEPTH)) ? fill_q[c1] : fill_q[c1] + FILL_W'(1);
      s2_d      = '{ch: s1_q.ch, val: PAY_W'(sum_new), valid: s1_q.valid};

      ave3_d = DATA_W'(SUM_W'(s2_q.val) >> LOG_D);
      s3_d   = '{ch: s2_q.ch, val: PAY_W'(PROD_W'(ave3_d) * PROD_W'(SCALE)), valid: s2_q.valid};

      c3        = IDX_W'(s3_q.ch);
      prod3     = PROD_W'(s3_q.val);
      sh        = prod3 >> SHIFT_FACTOR;
      sh_ofs    = (sh < OFS) ? '0 : sh - OFS;
      scaled4_d = (sh_ofs > SAT_MAX) ? {DATA_W{1'b1}} : DATA_W'(sh_ofs);
      upd_d     = '0;
      if (s3_q.valid) upd_d[c3] = 1'b1;
   end

   assign unused_payload = ^{s1_q.val[PAY_W-1:DATA_W], s2_q.val[PAY_W-1:SUM_W],
                             s3_q.val[PAY_W-1:PROD_W]};

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         overrun_q <= '0;
         primed_q  <= '0;
         upd_q     <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         ave3_q    <= '0;
         for (int i = 0; i < N_CH; i++) begin
            hold_q[i]   <= '0;
            sum_q[i]    <= '0;
            wp_q[i]     <= '0;
            fill_q[i]   <= '0;
            ave_q[i]    <= '0;
            scaled_q[i] <= '0;
            for (int j = 0; j < RING_N; j++) ring_q[i][j] <= '0;
         end
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         upd_q     <= upd_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         ave3_q    <= ave3_d;
         for (int i = 0; i < N_CH; i++) begin
            if (bus.sample_valid[i]) hold_q[i] <= bus.sample_data[i*DATA_W +: DATA_W];
         end
         if (s1_q.valid) begin
            ring_q[c1][wp_q[c1]] <= d1;
            wp_q[c1]             <= wp_next;
            sum_q[c1]            <= sum_new;
            fill_q[c1]           <= fill_next;
            if (fill_next == FILL_W'(DEPTH)) primed_q[c1] <= 1'b1;
         end
         if (s3_q.valid) begin
            ave_q[c3]    <= ave3_q;
            scaled_q[c3] <= scaled4_d;
         end
      end
   end

   always_comb begin
      bus.ave_data    = '0;
      bus.scaled_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         bus.ave_data[i*DATA_W +: DATA_W]    = ave_q[i];
         bus.scaled_data[i*DATA_W +: DATA_W] = scaled_q[i];
      end
      bus.update_valid = upd_q;
      bus.primed       = primed_q;
      bus.overrun      = overrun_q;
   end
endmodule

// File: tb/tb_multi_adc_processing.sv
// Directed bench for multi_adc_processing: four configurations driven side by side.
module tb_multi_adc_processing;
   localparam int DW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [DW-1:0] exp_q[$];

   // a: 1 ch, window 4 / b: 3 ch, window 1 / c: 1 ch, window 1, offset 3000 / d: 3 ch, window 4
   multi_adc_processing_if #(.N_CH(1), .DATA_W(DW)) if_a ();
   multi_adc_processing_if #(.N_CH(3), .DATA_W(DW)) if_b ();
   multi_adc_processing_if #(.N_CH(1), .DATA_W(DW)) if_c ();
   multi_adc_processing_if #(.N_CH(3), .DATA_W(DW)) if_d ();

   multi_adc_processing #(.N_CH(1), .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   multi_adc_processing #(.N_CH(3), .DEPTH(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
   multi_adc_processing #(.N_CH(1), .DEPTH(1), .OFFSET(3000)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));
   multi_adc_processing #(.N_CH(3), .DEPTH(4)) dut_d (.clk(clk), .reset(reset), .bus(if_d.slave));

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_a(input logic [DW-1:0] d);
      if_a.sample_data = d; if_a.sample_valid = 1'b1; tick(1); if_a.sample_valid = 1'b0;
   endtask

   task automatic pulse_b(input logic [2:0] m, input logic [DW-1:0] d2, d1, d0);
      if_b.sample_data = {d2, d1, d0}; if_b.sample_valid = m; tick(1); if_b.sample_valid = '0;
   endtask

   task automatic pulse_c(input logic [DW-1:0] d);
      if_c.sample_data = d; if_c.sample_valid = 1'b1; tick(1); if_c.sample_valid = 1'b0;
   endtask

   task automatic pulse_d(input logic [2:0] m, input logic [DW-1:0] d2, d1, d0);
      if_d.sample_data = {d2, d1, d0}; if_d.sample_valid = m; tick(1); if_d.sample_valid = '0;
   endtask

   task automatic expect_b(input string tag, input logic [2:0] upd, input int ch, input int ave);
      check({tag, "_upd"}, if_b.update_valid, upd);
      check({tag, "_ave"}, if_b.ave_data[ch*DW +: DW], ave);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int t1_in[5]  = '{100, 200, 300, 400, 500};
      int t1_ave[5] = '{25, 75, 150, 250, 350};
      int seen;

      if_a.sample_valid = '0; if_a.sample_data = '0; if_a.clear_overrun = 1'b0;
      if_b.sample_valid = '0; if_b.sample_data = '0; if_b.clear_overrun = 1'b0;
      if_c.sample_valid = '0; if_c.sample_data = '0; if_c.clear_overrun = 1'b0;
      if_d.sample_valid = '0; if_d.sample_data = '0; if_d.clear_overrun = 1'b0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);

      check("rst_a_ave", if_a.ave_data, 0);
      check("rst_b_upd", if_b.update_valid, 0);
      check("rst_b_scaled", if_b.scaled_data, 0);
      check("rst_d_primed", if_d.primed, 0);

      // Window of 4, sparse samples: the average ramps through the zero-filled window.
      foreach (t1_ave[k]) exp_q.push_back(DW'(t1_ave[k]));
      for (int k = 0; k < 5; k++) begin
         pulse_a(DW'(t1_in[k]));
         tick(3);
         check("t1_upd_early", if_a.update_valid, 0);
         tick(1);
         check("t1_upd", if_a.update_valid, 1);
         check("t1_ave", if_a.ave_data, exp_q.pop_front());
         check("t1_primed", if_a.primed, 64'(k >= 3));
         tick(1);
         check("t1_upd_one_cycle", if_a.update_valid, 0);
         tick(4);
      end

      // Simultaneous bursts are served 0, 1, 2 on consecutive cycles, twice.
      pulse_b(3'b111, 30, 20, 10);
      tick(3);
      check("t3_upd_early", if_b.update_valid, 0);
      tick(1); expect_b("t3a_ch0", 3'b001, 0, 10);
      tick(1); expect_b("t3a_ch1", 3'b010, 1, 20);
      tick(1); expect_b("t3a_ch2", 3'b100, 2, 30);
      tick(1);
      check("t3_idle", if_b.update_valid, 0);
      tick(2);
      pulse_b(3'b111, 60, 50, 40);
      tick(4); expect_b("t3b_ch0", 3'b001, 0, 40);
      tick(1); expect_b("t3b_ch1", 3'b010, 1, 50);
      tick(1); expect_b("t3b_ch2", 3'b100, 2, 60);
      tick(3);

      // Channel 2 overwritten while waiting.
      pulse_b(3'b111, 33, 22, 11);
      pulse_b(3'b100, 99, 0, 0);
      check("t4_overrun_set", if_b.overrun, 3'b100);
      tick(3); expect_b("t4_ch0", 3'b001, 0, 11);
      tick(1); expect_b("t4_ch1", 3'b010, 1, 22);
      tick(1); expect_b("t4_ch2", 3'b100, 2, 99);
      check("t4_ch2_scaled", if_b.scaled_data[2*DW +: DW], 58);
      if_b.clear_overrun = 1'b1; tick(1); if_b.clear_overrun = 1'b0;
      check("t4_overrun_clear", if_b.overrun, 0);
      tick(2);

      // A new overrun on the same edge as a clear survives the clear.
      pulse_b(3'b111, 3, 2, 1);
      if_b.clear_overrun = 1'b1;
      pulse_b(3'b100, 44, 0, 0);
      if_b.clear_overrun = 1'b0;
      check("t4_set_wins", if_b.overrun, 3'b100);
      tick(6);
      if_b.clear_overrun = 1'b1; tick(1); if_b.clear_overrun = 1'b0;
      check("t4_overrun_clear2", if_b.overrun, 0);

      // Strobe on channel 0 in the very cycle it is granted: no overrun, both samples served.
      pulse_b(3'b111, 7, 6, 5);
      pulse_b(3'b001, 0, 0, 77);
      check("t4_grant_same_cycle", if_b.overrun, 0);
      tick(3); expect_b("t4c_ch0_old", 3'b001, 0, 5);
      tick(1); expect_b("t4c_ch1", 3'b010, 1, 6);
      tick(1); expect_b("t4c_ch2", 3'b100, 2, 7);
      tick(1); expect_b("t4c_ch0_new", 3'b001, 0, 77);
      check("t4c_no_overrun", if_b.overrun, 0);
      tick(3);

      // Window of 1: scaling and saturation-free full-scale result.
      pulse_b(3'b001, 0, 0, 4096);
      tick(4);
      expect_b("t2_4096", 3'b001, 0, 4096);
      check("t2_4096_scaled", if_b.scaled_data[DW-1:0], 2428);
      tick(2);
      pulse_b(3'b001, 0, 0, 65535);
      tick(4);
      check("t2_65535_scaled", if_b.scaled_data[DW-1:0], 38857);
      check("t2_65535_ave", if_b.ave_data[DW-1:0], 65535);

      // Offset 3000: clamp at zero, and plain subtraction.
      pulse_c(4096);
      tick(4);
      check("t5_upd", if_c.update_valid, 1);
      check("t5_4096_ave", if_c.ave_data, 4096);
      check("t5_4096_clamp", if_c.scaled_data, 0);
      tick(2);
      pulse_c(65535);
      tick(4);
      check("t5_65535_scaled", if_c.scaled_data, 35857);

      // Back-to-back samples on one channel exercise the running sum every cycle.
      if_d.sample_valid = 3'b001;
      for (int k = 1; k <= 4; k++) begin
         if_d.sample_data = {16'd0, 16'd0, DW'(k * 100)};
         tick(1);
      end
      if_d.sample_valid = '0;
      tick(1); check("t6_b2b_1", if_d.ave_data[DW-1:0], 25);
      tick(1); check("t6_b2b_2", if_d.ave_data[DW-1:0], 75);
      tick(1); check("t6_b2b_3", if_d.ave_data[DW-1:0], 150);
      tick(1); check("t6_b2b_4", if_d.ave_data[DW-1:0], 250);
      check("t6_primed_before_reset", if_d.primed, 3'b001);
      tick(2);

      // Reset with three samples in flight.
      pulse_d(3'b111, 3000, 2000, 1000);
      tick(1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      check("t6_rst_ave", if_d.ave_data, 0);
      check("t6_rst_scaled", if_d.scaled_data, 0);
      check("t6_rst_primed", if_d.primed, 0);
      check("t6_rst_overrun", if_d.overrun, 0);
      check("t6_rst_upd", if_d.update_valid, 0);
      seen = 0;
      repeat (8) begin
         tick(1);
         if (if_d.update_valid != 3'b000) seen++;
      end
      check("t6_no_upd_after_reset", seen, 0);
      pulse_d(3'b001, 0, 0, 400);
      tick(4);
      check("t6_post_upd", if_d.update_valid, 3'b001);
      check("t6_post_ave", if_d.ave_data[DW-1:0], 100);
      check("t6_post_scaled", if_d.scaled_data[DW-1:0], 59);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_adc_processing.md
Name: multi_adc_processing

Overview:
N-channel successor to the single-channel ADC post-processor. It accepts ready-pulsed raw samples from up to N_CH converters (XADC, PWM ramp/SA, R2R, future channels). Each channel has a power-of-two moving average and fixed-point voltage scaling with offset and clamp. One time-multiplexed arithmetic pipeline is shared by all channels through a round-robin arbiter, replacing the per-ADC processing instances under the top level.

Parameters:
N_CH, 3, number of input channels (1..8)
DATA_W, 16, raw sample width
DEPTH, 16, moving-average window per channel; power of two, 1..64
SCALING_FACTOR, 310866, unsigned multiplier applied to the average
SCALE_W, 20, width of SCALING_FACTOR (must hold it)
SHIFT_FACTOR, 19, right shift applied after the multiply
OFFSET, 0, unsigned value subtracted after the shift; result clamps at 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_valid  in  N_CH  1-cycle ready pulse per channel
sample_data  in  N_CH*DATA_W  raw samples; channel i at [i*DATA_W +: DATA_W]
clear_overrun  in  1  clears all overrun flags
ave_data  out  N_CH*DATA_W  latest moving average per channel
scaled_data  out  N_CH*DATA_W  latest scaled value per channel, saturated to DATA_W
update_valid  out  N_CH  1-cycle pulse when channel i outputs refresh
primed  out  N_CH  channel i has received at least DEPTH samples since reset
overrun  out  N_CH  sticky: channel i sample overwritten before service

Behaviour:
- Reset: all outputs 0. Hold regs, pending flags, sums, ring buffers, write pointers and fill counters are 0. Arbiter pointer is at channel 0. In-flight pipeline entries are discarded and no update_valid fires.
- Capture (edge E0, the cycle sample_valid[i]=1): hold[i] <= sample, pending[i] <= 1.
  - If pending[i] is already 1 and is not granted this cycle: overwrite hold[i] and set overrun[i].
  - Valid and grant on the same channel in the same cycle: granted data is the old hold; new data is captured, pending stays 1, no overrun.
- Overrun flags: clear_overrun zeroes all flags. A set on the same edge wins.
- Stage 1 (edge E1): the round-robin arbiter grants one pending channel per cycle. Priority starts at the channel after the last grant. Loads s1 {ch, data} and clears that channel's pending flag.
- Stage 2 (E2): sum_new = sum[ch] - ring[ch][wp[ch]] + data. Then ring[ch][wp[ch]] <= data, wp[ch] wraps modulo DEPTH, sum[ch] <= sum_new, fill[ch] saturates at DEPTH, and primed[ch] is set when fill reaches DEPTH.
  - Sum width is DATA_W + log2(DEPTH).
  - The next cycle's stage 2 must see the updated sum and pointer, so back-to-back grants of the same channel are hazard-free.
- Stage 3 (E3): ave = sum_new >> log2(DEPTH), computed on the registered sum. prod = ave * SCALING_FACTOR, width DATA_W + SCALE_W.
- Stage 4 (E4): sh = prod >> SHIFT_FACTOR; val = sh - OFFSET, clamped to 0 if sh < OFFSET, then saturated to 2^DATA_W - 1. Writes ave_data[ch] and scaled_data[ch]; update_valid[ch] is high for exactly this cycle.
- Latency: update_valid occurs 4 cycles after sample_valid if uncontended. Each channel granted ahead adds 1 cycle. Throughput is one sample per cycle aggregate.
- Before a channel is primed, the window contains zeros, so the average ramps up. This is intentional.
- Channel outputs hold their values between updates.

Decomposition:
- Package adc_proc_pkg holds:
  - the log2 helper function;
  - the localparams for derived widths (SUM_W, PROD_W, PTR_W);
  - a typedef for the pipeline stage struct {ch index, data/sum, valid}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and advance; outputs grant one-hot and grant_idx; rotating priority pointer; synchronous reset to 0.

Test Plan:
1. N_CH=1, DEPTH=4, OFFSET=0. Samples 100, 200, 300, 400, 500 spaced 10 cycles apart -> ave_data is 25, 75, 150, 250, 350. update_valid fires exactly 4 cycles after each input. primed rises with the 4th update.
2. DEPTH=1, single sample 4096 -> ave_data=4096, scaled_data=2428. Sample 65535 -> scaled_data=38857.
3. N_CH=3, all sample_valid high in one cycle with 10, 20, 30 (DEPTH=1) -> update_valid[0], [1], [2] pulse on consecutive cycles +4, +5, +6. The next simultaneous burst starts priority from channel 0 again (after channel 2).
4. Overrun: all 3 valid at cycle t, then ch2 valid again at t+1 with 99 -> overrun[2]=1 and ch2 output uses 99. Pulsing clear_overrun -> overrun=0. Same-cycle valid+grant on ch0 -> no overrun.
5. OFFSET=3000, DEPTH=1, sample 4096 -> scaled_data=0 (clamp). Sample 65535 -> scaled_data=35857.
6. Reset asserted while 3 samples are in flight -> no update_valid after reset. All outputs, primed and overrun are 0. The first post-reset sample of 400 with DEPTH=4 gives ave_data=100.
